// File: rtl/uart_rx_intr.sv
// uart_rx_intr: 8N1 UART receiver with a CPU-facing data register and a level interrupt.
//
// The last correctly framed byte is held in r_data. intr stays high until the CPU
// acknowledges it with ack.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   uart_rx    in   asynchronous serial line, idles high
//   ack        in   one-cycle interrupt acknowledge; clears intr and overrun
//   r_data     out  last correctly framed byte
//   intr       out  level request: an unread byte is pending
//   overrun    out  sticky: a byte completed while intr was already high
//   frame_err  out  one-cycle pulse on a bad stop bit
module uart_rx_intr #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic       ack,
    output logic [7:0] r_data,
    output logic       intr,
    output logic       overrun,
    output logic       frame_err
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e          r_state;
    logic            r_rx_s1;
    logic            r_rx_s2;
    logic [CntW-1:0] r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_sh;

    // Two-flop synchroniser; reset to the idle line level so reset never looks like a start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= uart_rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            r_sh      <= 8'h00;
            r_data    <= 8'h00;
            intr      <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            // The acknowledge clears the flags. A commit in the same cycle overrides this below.
            if (ack) begin
                intr    <= 1'b0;
                overrun <= 1'b0;
            end
            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (!r_rx_s2) begin
                        r_state <= StStart;
                    end
                end
                StStart: begin
                    if (r_cnt == HalfLast) begin
                        r_cnt <= '0;
                        r_idx <= 3'd0;
                        r_state <= r_rx_s2 ? StIdle : StData;
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                    end
                end
                StData: begin
                    if (r_cnt == BitLast) begin
                        r_cnt <= '0;
                        r_sh  <= {r_rx_s2, r_sh[7:1]};
                        if (r_idx == 3'd7) begin
                            r_state <= StStop;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                    end
                end
                StStop: begin
                    if (r_cnt == BitLast) begin
                        r_cnt <= '0;
                        if (r_rx_s2) begin
                            r_data  <= r_sh;
                            intr    <= 1'b1;
                            // An acknowledge in the commit cycle consumed the old byte.
                            overrun <= ack ? 1'b0 : (overrun | intr);
                            r_state <= StIdle;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= StBreak;
                        end
                    end else begin
                        r_cnt <= r_cnt + CntOne;
                    end
                end
                StBreak: begin
                    r_cnt <= '0;
                    // Wait for the line to return high so a held-low line cannot re-trigger.
                    if (r_rx_s2) begin
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
